// File: rtl/aes_subbytes_iter.sv
// rtl/aes_subbytes_iter.sv - iterative AES SubBytes/InvSubBytes engine, LANES S-boxes per cycle
// Valid/ready on both sides; the result is held in the working register until the next accept.
module aes_subbytes_iter #(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  inv_i,
  input  logic [8*NBYTES-1:0]   state_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [8*NBYTES-1:0]   state_o,
  output logic                  busy_o
);

  localparam int ITER = NBYTES / LANES;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if (NBYTES % LANES != 0) begin : g_bad_lanes
    $error("aes_subbytes_iter: NBYTES must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [8*NBYTES-1:0] work_q, work_nxt;
  logic [CW-1:0]       cnt_q;
  logic                mode_q;
  logic [8*LANES-1:0]  grp, sub;
  int                  base;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // One shared inverter per lane serves both directions.
  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    logic [7:0] u;
    u = gf_inv(inv ? aff_inv(b) : b);
    return inv ? u : aff_fwd(u);
  endfunction

  always_comb begin
    base     = 8*NBYTES - 1 - 8*LANES*int'(cnt_q);
    grp      = work_q[base -: 8*LANES];
    sub      = '0;
    for (int l = 0; l < LANES; l++) begin
      sub[8*LANES-1-8*l -: 8] = sbox(grp[8*LANES-1-8*l -: 8], mode_q);
    end
    work_nxt = work_q;
    work_nxt[base -: 8*LANES] = sub;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) state_d = BUSY;
      end
      BUSY: if (cnt_q == LAST) state_d = DONE;
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid_i) begin
          work_q <= state_i;
          mode_q <= inv_i;
          cnt_q  <= '0;
        end
        BUSY: begin
          work_q <= work_nxt;
          if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign state_o = work_q;

endmodule

// File: tb/tb_aes_subbytes_iter.sv
// tb/tb_aes_subbytes_iter.sv - directed bench for aes_subbytes_iter at LANES = 1, 2, 4, 16
// All four instances share stimulus; index 2 (LANES=4) is the primary engine.
module tb_aes_subbytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         inv;
  logic         out_ready;
  logic [127:0] state_in;
  logic [3:0]   in_ready, out_valid, busy;
  logic [127:0] st_o [4];
  int           vectors = 0;
  int           miscompares = 0;

  localparam logic [127:0] VA  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VB  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] F63 = {16{8'h63}};
  localparam logic [127:0] F52 = {16{8'h52}};

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    aes_subbytes_iter #(.NBYTES(16), .LANES(k == 3 ? 16 : (1 << k))) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready[k]),
      .inv_i      (inv),
      .state_i    (state_in),
      .out_valid_o(out_valid[k]),
      .out_ready_i(out_ready),
      .state_o    (st_o[k]),
      .busy_o     (busy[k])
    );
  end

  function automatic logic [7:0] sb(input int x);
    return SBOX[2047-8*x -: 8];
  endfunction

  function automatic int lanes_of(input int k);
    return (k == 3) ? 16 : (1 << k);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drain;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && in_ready != 4'hf; c++) step;
    check("drain to idle", 128'(in_ready), 128'hf);
  endtask

  // One accept on all instances, then result and latency per instance.
  task automatic run(input string tag, input logic [127:0] vin, input logic m,
                     input logic [127:0] vexp);
    logic [3:0]   seen;
    int           lat [4];
    logic [127:0] res [4];
    seen = '0;
    for (int k = 0; k < 4; k++) begin lat[k] = 0; res[k] = '0; end
    drain;
    in_valid = 1'b1;
    state_in = vin;
    inv      = m;
    step;
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    inv      = ~m;
    for (int c = 1; c <= 24 && seen != 4'hf; c++) begin
      step;
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && !seen[k]) begin
          seen[k] = 1'b1;
          lat[k]  = c;
          res[k]  = st_o[k];
        end
      end
    end
    check($sformatf("%s all done", tag), 128'(seen), 128'hf);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s L%0d data", tag, lanes_of(k)), res[k], vexp);
      check($sformatf("%s L%0d latency", tag, lanes_of(k)), 128'(lat[k]), 128'(16 / lanes_of(k)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] vin, vx;
    logic [127:0] b_in [4], b_exp [4], b_res [8];
    logic         b_m [4];
    int           acc_t [4];
    int           na, nr;
    logic         rdy;

    rst = 1'b1; in_valid = 1'b0; inv = 1'b0; out_ready = 1'b1; state_in = '0;
    #12;
    check("reset state_o", st_o[2], '0);
    check("reset out_valid", 128'(out_valid), 128'h0);
    check("reset busy", 128'(busy), 128'h0);
    check("reset in_ready", 128'(in_ready), 128'hf);
    rst = 1'b0;
    step;

    run("fips fwd", VA, 1'b0, VB);
    run("fips inv", VB, 1'b1, VA);
    run("zero fwd", '0, 1'b0, F63);
    run("zero inv", '0, 1'b1, F52);

    // Backpressure: result must hold through a 5-cycle stall.
    drain;
    out_ready = 1'b0; in_valid = 1'b1; state_in = VA; inv = 1'b0;
    step;
    in_valid = 1'b0;
    step; step; step;
    check("bp not early", 128'(out_valid[2]), 128'h0);
    step;
    check("bp valid", 128'(out_valid[2]), 128'h1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      inv      = ~inv;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      step;
      check($sformatf("bp stall %0d data", i), st_o[2], VB);
      check($sformatf("bp stall %0d valid", i), 128'(out_valid[2]), 128'h1);
      check($sformatf("bp stall %0d ready", i), 128'(in_ready[2]), 128'h0);
    end
    in_valid = 1'b1; state_in = '0; inv = 1'b0; out_ready = 1'b1;
    step;
    check("bp release idle", 128'(in_ready[2]), 128'h1);
    check("bp release valid low", 128'(out_valid[2]), 128'h0);
    check("bp no accept in done", 128'(busy[2]), 128'h0);
    step;
    check("bp accept after", 128'(busy[2]), 128'h1);
    in_valid = 1'b0;
    step; step; step; step;
    check("bp second valid", 128'(out_valid[2]), 128'h1);
    check("bp second data", st_o[2], F63);

    // Asynchronous reset between edges with the LANES=4 engine at cnt=2.
    drain;
    in_valid = 1'b1; state_in = VA; inv = 1'b0;
    step;
    in_valid = 1'b0;
    step; step;
    #2 rst = 1'b1;
    #1;
    check("midrst state_o", st_o[2], '0);
    check("midrst busy", 128'(busy), 128'h0);
    check("midrst in_ready", 128'(in_ready), 128'hf);
    check("midrst out_valid", 128'(out_valid), 128'h0);
    #1 rst = 1'b0;
    run("post reset fwd", VA, 1'b0, VB);

    // Exhaustive byte sweep, 16 bytes per state.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) begin
        vin[127-8*j -: 8] = 8'(16*k + j);
        vx[127-8*j -: 8]  = sb(16*k + j);
      end
      run($sformatf("sweep fwd %0d", k), vin, 1'b0, vx);
      run($sformatf("sweep inv %0d", k), vx, 1'b1, vin);
    end

    // Back-to-back with in_valid held high and a mode toggle per state.
    b_in[0] = VA; b_m[0] = 1'b0; b_exp[0] = VB;
    b_in[1] = VB; b_m[1] = 1'b1; b_exp[1] = VA;
    b_in[2] = '0; b_m[2] = 1'b0; b_exp[2] = F63;
    b_in[3] = '0; b_m[3] = 1'b1; b_exp[3] = F52;
    for (int i = 0; i < 8; i++) b_res[i] = '0;
    for (int i = 0; i < 4; i++) acc_t[i] = 0;
    drain;
    na = 0; nr = 0;
    in_valid = 1'b1; state_in = b_in[0]; inv = b_m[0];
    for (int cyc = 1; cyc <= 40; cyc++) begin
      rdy = in_ready[2];
      step;
      if (rdy && in_valid) begin
        acc_t[na] = cyc;
        na++;
        if (na < 4) begin
          state_in = b_in[na];
          inv      = b_m[na];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid[2]) begin
        if (nr < 8) b_res[nr] = st_o[2];
        nr++;
      end
    end
    check("b2b accepts", 128'(na), 128'd4);
    check("b2b results", 128'(nr), 128'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b result %0d", i), b_res[i], b_exp[i]);
      if (i > 0) check($sformatf("b2b spacing %0d", i), 128'(acc_t[i] - acc_t[i-1]), 128'd6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
